loader_write_arbiter: RTL and testbench

Shares one byte-wide memory write port between two writers: core-side writes and the bridge data loader's byte stream. Core writes have absolute priority and no backpressure. Loader bytes are buffered in a small FIFO and issued with a programmable minimum spacing. The block sits between the data loader / core logic and the RAM write port, and replaces fixed-delay pacing inside the loader with proper valid/ready flow control.

---
 rtl/loader_write_arbiter_pkg.sv | 27 ++
 rtl/loader_write_arbiter_if.sv | 63 ++++++
 rtl/loader_write_arbiter_sync_byte_fifo.sv | 91 +++++++++
 rtl/loader_write_arbiter.sv | 174 +++++++++++++++++
 tb/tb_loader_write_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// loader_write_arbiter_pkg
//
// Shared definitions for the loader write arbiter slice:
//   - arb_state_t  : issue FSM encoding (IDLE / ISSUE / GAP)
//   - GAP_CNT_W    : width of the inter-write gap counter
//   - entry_width(): width of one loader FIFO entry ({address, data})
// -----------------------------------------------------------------------------
package loader_write_arbiter_pkg;

    // Issue FSM encoding. Values are fixed so that state dumps stay readable
    // against older captures of the loader.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // FIFO empty, gap counter zero
        ISSUE = 2'd1,   // FIFO holds data, gap counter zero: may pop
        GAP   = 2'd2    // spacing loader writes, gap counter nonzero
    } arb_state_t;

    // Gap counter width; WRITE_GAP must fit (0..255).
    localparam int GAP_CNT_W = 8;

    // One FIFO entry carries the full memory address plus the data byte.
    function automatic int entry_width(input int address_size);
        return address_size + 1 + 8;
    endfunction

endpackage : loader_write_arbiter_pkg

// File: rtl/loader_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// loader_write_arbiter_if
//
// Bundles the core write strobe, the loader valid/ready byte stream, the flush
// control and the RAM write port seen by loader_write_arbiter.
//
// Signals:
//   core_wr/core_addr/core_data : core-side write, one write per high cycle
//   ld_valid/ld_ready           : loader byte handshake
//   ld_addr/ld_data             : loader byte address and data
//   flush                       : synchronous clear of queued loader bytes
//   mem_we/mem_addr/mem_data    : registered RAM write port
//   fifo_count                  : loader FIFO occupancy
//   idle                        : nothing queued, no gap running, no write
//
// Modports:
//   master : the side producing writes (core logic + data loader)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface loader_write_arbiter_if #(
    parameter int ADDRESS_SIZE = 14,
    parameter int FIFO_DEPTH   = 4
);
    localparam int AW = ADDRESS_SIZE + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          core_wr;
    logic [AW-1:0] core_addr;
    logic [7:0]    core_data;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;

    logic          flush;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;

    logic [CW-1:0] fifo_count;
    logic          idle;

    modport master (
        output core_wr, core_addr, core_data,
        output ld_valid, ld_addr, ld_data,
        output flush,
        input  ld_ready,
        input  mem_we, mem_addr, mem_data,
        input  fifo_count, idle
    );

    modport slave (
        input  core_wr, core_addr, core_data,
        input  ld_valid, ld_addr, ld_data,
        input  flush,
        output ld_ready,
        output mem_we, mem_addr, mem_data,
        output fifo_count, idle
    );

endinterface : loader_write_arbiter_if

// File: rtl/loader_write_arbiter_sync_byte_fifo.sv
// -----------------------------------------------------------------------------
// sync_byte_fifo
//
// Single-clock FIFO used to queue loader bytes (address + data) in front of
// the shared RAM write port.
//
// Ports:
//   clk_74a   : clock
//   reset     : asynchronous active-high reset (empties the FIFO)
//   clr       : synchronous clear; wins over push and pop in the same cycle
//   push      : write push_data (ignored when full)
//   push_data : entry to enqueue
//   pop       : drop the head entry (ignored when empty)
//   pop_data  : head entry, valid whenever empty is low
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : occupancy, 0..DEPTH
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_byte_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic                       clk_74a,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // Guarding here as well as upstream keeps the FIFO self-consistent even if
    // a caller ignores full/empty.
    assign do_push = push && !full && !clr;
    assign do_pop  = pop  && !empty && !clr;

    // Storage has no reset: contents are meaningless while count is zero.
    always_ff @(posedge clk_74a) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Head is read combinationally so a pop and the RAM write it feeds happen
    // on the same edge.
    assign pop_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule : sync_byte_fifo

// File: rtl/loader_write_arbiter.sv
// -----------------------------------------------------------------------------
// loader_write_arbiter
//
// Shares one byte-wide RAM write port between core writes and the data
// loader's byte stream. Core writes always win and are never stalled. Loader
// bytes are queued in a small FIFO and issued no closer than WRITE_GAP idle
// cycles apart.
//
// Parameters:
//   ADDRESS_SIZE : RAM address is ADDRESS_SIZE+1 bits
//   FIFO_DEPTH   : loader FIFO entries (power of two, >= 2)
//   WRITE_GAP    : idle cycles between loader-issued writes (0..255)
//
// Ports:
//   clk_74a : clock
//   reset   : asynchronous active-high reset
//   bus     : loader_write_arbiter_if.slave (core write, loader stream,
//             flush, RAM write port, fifo_count, idle)
//
// Timing:
//   core_wr sampled at edge k  -> mem_we high after edge k
//   push at edge k (idle)      -> mem_we high after edge k+1
//   loader writes spaced WRITE_GAP+1 cycles apart without core traffic
// -----------------------------------------------------------------------------
module loader_write_arbiter
    import loader_write_arbiter_pkg::*;
#(
    parameter int ADDRESS_SIZE = 14,
    parameter int FIFO_DEPTH   = 4,
    parameter int WRITE_GAP    = 4
) (
    input  logic                   clk_74a,
    input  logic                   reset,
    loader_write_arbiter_if.slave  bus
);
    localparam int AW = ADDRESS_SIZE + 1;
    localparam int EW = entry_width(ADDRESS_SIZE);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(WRITE_GAP);

    arb_state_t           state_reg;
    arb_state_t           state_next;
    logic [GAP_CNT_W-1:0] gap_cnt_reg;
    logic [GAP_CNT_W-1:0] gap_cnt_next;

    logic                 mem_we_reg;
    logic [AW-1:0]        mem_addr_reg;
    logic [7:0]           mem_data_reg;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [EW-1:0]        fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic                 ld_ready_int;

    // ---------------------------------------------------------------------
    // Loader handshake. Ready depends only on the registered occupancy, so a
    // full FIFO refuses a byte even when a pop frees a slot on that edge.
    // Held low throughout reset.
    // ---------------------------------------------------------------------
    assign ld_ready_int = !reset && !fifo_full && !bus.flush;
    assign fifo_push    = bus.ld_valid && ld_ready_int;

    sync_byte_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_74a   (clk_74a),
        .reset     (reset),
        .clr       (bus.flush),
        .push      (fifo_push),
        .push_data ({bus.ld_addr, bus.ld_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------------------------------------------------------------
    // Issue FSM: next state, gap counter and pop decision.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        fifo_pop     = 1'b0;

        // The gap keeps running through core writes.
        if (gap_cnt_reg != '0) begin
            gap_cnt_next = gap_cnt_reg - GAP_CNT_W'(1);
        end

        unique case (state_reg)
            IDLE: begin
                // Going to ISSUE on the push edge lets the byte be popped on
                // the very next edge.
                if (fifo_push) begin
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                // A core write takes the port; the loader byte waits in ISSUE.
                if (!bus.core_wr && !fifo_empty) begin
                    fifo_pop     = 1'b1;
                    gap_cnt_next = GAP_LOAD;
                    if (GAP_LOAD != '0) begin
                        state_next = GAP;
                    end else if ((fifo_count != CW'(1)) || fifo_push) begin
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            GAP: begin
                // Counter reaches zero on this edge.
                if (gap_cnt_reg <= GAP_CNT_W'(1)) begin
                    state_next = (!fifo_empty || fifo_push) ? ISSUE : IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Flush drops everything queued, including a pop due this cycle.
        if (bus.flush) begin
            state_next   = IDLE;
            gap_cnt_next = '0;
            fifo_pop     = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // State and RAM write port registers. mem_we is a one-cycle pulse per
    // write; address/data hold their last value between writes.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            gap_cnt_reg  <= '0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            if (bus.core_wr) begin
                mem_we_reg   <= 1'b1;
                mem_addr_reg <= bus.core_addr;
                mem_data_reg <= bus.core_data;
            end else if (fifo_pop) begin
                mem_we_reg   <= 1'b1;
                mem_addr_reg <= fifo_head[EW-1:8];
                mem_data_reg <= fifo_head[7:0];
            end else begin
                mem_we_reg   <= 1'b0;
            end
        end
    end

    assign bus.ld_ready   = ld_ready_int;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_data   = mem_data_reg;
    assign bus.fifo_count = fifo_count;
    assign bus.idle       = (fifo_count == '0) && (gap_cnt_reg == '0) && !mem_we_reg;

endmodule : loader_write_arbiter

// File: tb/tb_loader_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_loader_write_arbiter
//
// Two arbiters share clock and reset: dut_g4 (WRITE_GAP=4) and dut_g0
// (WRITE_GAP=0). A cycle table covers in-order pacing and FIFO-full
// behaviour; hand-written sequences cover core priority, flush, async reset
// mid-gap and back-to-back draining with no gap.
// -----------------------------------------------------------------------------
module tb_loader_write_arbiter;

    localparam int AS = 14;
    localparam int AW = AS + 1;

    logic clk_74a = 1'b0;
    logic reset;

    always #5 clk_74a = ~clk_74a;

    loader_write_arbiter_if #(.ADDRESS_SIZE(AS), .FIFO_DEPTH(4)) if_g4 ();
    loader_write_arbiter_if #(.ADDRESS_SIZE(AS), .FIFO_DEPTH(4)) if_g0 ();

    loader_write_arbiter #(.ADDRESS_SIZE(AS), .FIFO_DEPTH(4), .WRITE_GAP(4)) dut_g4 (
        .clk_74a (clk_74a),
        .reset   (reset),
        .bus     (if_g4)
    );

    loader_write_arbiter #(.ADDRESS_SIZE(AS), .FIFO_DEPTH(4), .WRITE_GAP(0)) dut_g0 (
        .clk_74a (clk_74a),
        .reset   (reset),
        .bus     (if_g0)
    );

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic          ld_valid;
        logic [AW-1:0] ld_addr;
        logic [7:0]    ld_data;
        logic          exp_ready;   // ld_ready during this cycle
        logic          exp_we;      // after the edge
        logic [AW-1:0] exp_addr;
        logic [7:0]    exp_data;
        logic [2:0]    exp_count;
        logic          exp_idle;
    } vec_t;

    vec_t vecs[$];

    // One line per RAM write seen.
    always @(negedge clk_74a) begin
        if (if_g4.mem_we) $display("[TB] g4 write addr=%h data=%h", if_g4.mem_addr, if_g4.mem_data);
        if (if_g0.mem_we) $display("[TB] g0 write addr=%h data=%h", if_g0.mem_addr, if_g0.mem_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_74a);
        #1;
    endtask

    task automatic add(input logic v, input logic [AW-1:0] a, input logic [7:0] d,
                       input logic rdy, input logic we, input logic [AW-1:0] ea,
                       input logic [7:0] ed, input logic [2:0] cnt, input logic idl);
        vec_t t;
        t.ld_valid = v;   t.ld_addr = a;    t.ld_data = d;
        t.exp_ready = rdy; t.exp_we = we;   t.exp_addr = ea; t.exp_data = ed;
        t.exp_count = cnt; t.exp_idle = idl;
        vecs.push_back(t);
    endtask

    task automatic add_wait(input int n, input logic rdy, input logic [2:0] cnt, input logic idl);
        repeat (n) add(1'b0, '0, 8'h00, rdy, 1'b0, '0, 8'h00, cnt, idl);
    endtask

    task automatic drive4(input logic v, input logic [AW-1:0] a, input logic [7:0] d,
                          input logic c, input logic [AW-1:0] ca, input logic [7:0] cd,
                          input logic f);
        if_g4.ld_valid = v;  if_g4.ld_addr = a;    if_g4.ld_data = d;
        if_g4.core_wr = c;   if_g4.core_addr = ca; if_g4.core_data = cd;
        if_g4.flush = f;
    endtask

    // Check mem_we and occupancy; address/data only matter on a write.
    task automatic exp4(input string name, input logic we, input logic [AW-1:0] a,
                        input logic [7:0] d, input logic [2:0] cnt);
        chk({name, "_we"}, 32'(if_g4.mem_we), 32'(we));
        chk({name, "_cnt"}, 32'(if_g4.fifo_count), 32'(cnt));
        if (we) begin
            chk({name, "_addr"}, 32'(if_g4.mem_addr), 32'(a));
            chk({name, "_data"}, 32'(if_g4.mem_data), 32'(d));
        end
    endtask

    initial begin
        reset = 1'b1;
        drive4(1'b0, '0, 8'h00, 1'b0, '0, 8'h00, 1'b0);
        if_g0.ld_valid = 1'b0; if_g0.ld_addr = '0;   if_g0.ld_data = 8'h00;
        if_g0.core_wr = 1'b0;  if_g0.core_addr = '0; if_g0.core_data = 8'h00;
        if_g0.flush = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk_74a);
        #1;
        chk("rst_we",    32'(if_g4.mem_we), 32'd0);
        chk("rst_addr",  32'(if_g4.mem_addr), 32'd0);
        chk("rst_data",  32'(if_g4.mem_data), 32'd0);
        chk("rst_cnt",   32'(if_g4.fifo_count), 32'd0);
        chk("rst_idle",  32'(if_g4.idle), 32'd1);
        chk("rst_ready", 32'(if_g4.ld_ready), 32'd0);
        #2 reset = 1'b0;
        #1 chk("rel_ready", 32'(if_g4.ld_ready), 32'd1);
        step();

        // ---------------- table: 4 bytes, gap 4 ----------------
        add(1'b1, 15'h0000, 8'hA0, 1'b1, 1'b0, '0, 8'h00, 3'd1, 1'b0);
        add(1'b1, 15'h0001, 8'hA1, 1'b1, 1'b1, 15'h0000, 8'hA0, 3'd1, 1'b0);
        add(1'b1, 15'h0002, 8'hA2, 1'b1, 1'b0, '0, 8'h00, 3'd2, 1'b0);
        add(1'b1, 15'h0003, 8'hA3, 1'b1, 1'b0, '0, 8'h00, 3'd3, 1'b0);
        add_wait(2, 1'b1, 3'd3, 1'b0);
        add(1'b0, '0, 8'h00, 1'b1, 1'b1, 15'h0001, 8'hA1, 3'd2, 1'b0);
        add_wait(4, 1'b1, 3'd2, 1'b0);
        add(1'b0, '0, 8'h00, 1'b1, 1'b1, 15'h0002, 8'hA2, 3'd1, 1'b0);
        add_wait(4, 1'b1, 3'd1, 1'b0);
        add(1'b0, '0, 8'h00, 1'b1, 1'b1, 15'h0003, 8'hA3, 3'd0, 1'b0);
        add_wait(3, 1'b1, 3'd0, 1'b0);
        add_wait(2, 1'b1, 3'd0, 1'b1);

        // ---------------- table: 5 bytes into a 4-deep FIFO ----------------
        add(1'b1, 15'h0010, 8'hB0, 1'b1, 1'b0, '0, 8'h00, 3'd1, 1'b0);
        add(1'b1, 15'h0011, 8'hB1, 1'b1, 1'b1, 15'h0010, 8'hB0, 3'd1, 1'b0);
        add(1'b1, 15'h0012, 8'hB2, 1'b1, 1'b0, '0, 8'h00, 3'd2, 1'b0);
        add(1'b1, 15'h0013, 8'hB3, 1'b1, 1'b0, '0, 8'h00, 3'd3, 1'b0);
        add(1'b1, 15'h0014, 8'hB4, 1'b1, 1'b0, '0, 8'h00, 3'd4, 1'b0);
        // Full: an offered byte is refused, even on the popping edge.
        add(1'b1, 15'h0015, 8'hB5, 1'b0, 1'b0, '0, 8'h00, 3'd4, 1'b0);
        add(1'b1, 15'h0015, 8'hB5, 1'b0, 1'b1, 15'h0011, 8'hB1, 3'd3, 1'b0);
        add_wait(4, 1'b1, 3'd3, 1'b0);
        add(1'b0, '0, 8'h00, 1'b1, 1'b1, 15'h0012, 8'hB2, 3'd2, 1'b0);
        add_wait(4, 1'b1, 3'd2, 1'b0);
        add(1'b0, '0, 8'h00, 1'b1, 1'b1, 15'h0013, 8'hB3, 3'd1, 1'b0);
        add_wait(4, 1'b1, 3'd1, 1'b0);
        add(1'b0, '0, 8'h00, 1'b1, 1'b1, 15'h0014, 8'hB4, 3'd0, 1'b0);
        add_wait(3, 1'b1, 3'd0, 1'b0);
        add_wait(2, 1'b1, 3'd0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            if_g4.ld_valid = vecs[i].ld_valid;
            if_g4.ld_addr  = vecs[i].ld_addr;
            if_g4.ld_data  = vecs[i].ld_data;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(if_g4.ld_ready), 32'(vecs[i].exp_ready));
            step();
            exp4($sformatf("v%0d", i), vecs[i].exp_we, vecs[i].exp_addr,
                 vecs[i].exp_data, vecs[i].exp_count);
            chk($sformatf("v%0d_idle", i), 32'(if_g4.idle), 32'(vecs[i].exp_idle));
        end
        drive4(1'b0, '0, 8'h00, 1'b0, '0, 8'h00, 1'b0);

        // ---------------- core priority over a due loader byte ----------------
        drive4(1'b1, 15'h0040, 8'h77, 1'b0, '0, 8'h00, 1'b0);
        step(); exp4("core_e1", 1'b0, '0, 8'h00, 3'd1);
        drive4(1'b1, 15'h0041, 8'h78, 1'b1, 15'h1234, 8'h55, 1'b0);
        step(); exp4("core_e2", 1'b1, 15'h1234, 8'h55, 3'd2);
        drive4(1'b0, '0, 8'h00, 1'b1, 15'h1234, 8'h55, 1'b0);
        step(); exp4("core_e3", 1'b1, 15'h1234, 8'h55, 3'd2);
        step(); exp4("core_e4", 1'b1, 15'h1234, 8'h55, 3'd2);
        drive4(1'b0, '0, 8'h00, 1'b0, '0, 8'h00, 1'b0);
        step(); exp4("core_e5", 1'b1, 15'h0040, 8'h77, 3'd1);
        step(); exp4("core_e6", 1'b0, '0, 8'h00, 3'd1);
        // Core write during the gap does not stretch it.
        drive4(1'b0, '0, 8'h00, 1'b1, 15'h1234, 8'h56, 1'b0);
        step(); exp4("core_e7", 1'b1, 15'h1234, 8'h56, 3'd1);
        drive4(1'b0, '0, 8'h00, 1'b0, '0, 8'h00, 1'b0);
        step(); exp4("core_e8", 1'b0, '0, 8'h00, 3'd1);
        step(); exp4("core_e9", 1'b0, '0, 8'h00, 3'd1);
        step(); exp4("core_e10", 1'b1, 15'h0041, 8'h78, 3'd0);
        repeat (3) step();
        chk("core_idle0", 32'(if_g4.idle), 32'd0);
        step();
        chk("core_idle1", 32'(if_g4.idle), 32'd1);

        // ---------------- flush with 3 queued and a core write ----------------
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, AW'(16'h0050 + i), 8'(8'hC0 + i), 1'b0, '0, 8'h00, 1'b0);
            step();
        end
        chk("fl_pre_cnt", 32'(if_g4.fifo_count), 32'd3);
        drive4(1'b1, 15'h0054, 8'hC4, 1'b1, 15'h0777, 8'h99, 1'b1);
        #1 chk("fl_ready", 32'(if_g4.ld_ready), 32'd0);
        step(); exp4("fl_e1", 1'b1, 15'h0777, 8'h99, 3'd0);
        drive4(1'b0, '0, 8'h00, 1'b0, '0, 8'h00, 1'b0);
        step(); exp4("fl_e2", 1'b0, '0, 8'h00, 3'd0);
        chk("fl_idle", 32'(if_g4.idle), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("fl_quiet%0d", i), 32'(if_g4.mem_we), 32'd0);
        end

        // ---------------- async reset mid-gap, 2 queued ----------------
        for (int i = 0; i < 3; i++) begin
            drive4(1'b1, AW'(16'h0060 + i), 8'(8'hD0 + i), 1'b0, '0, 8'h00, 1'b0);
            step();
        end
        drive4(1'b0, '0, 8'h00, 1'b1, 15'h0100, 8'h11, 1'b0);
        step(); exp4("rs_pre", 1'b1, 15'h0100, 8'h11, 3'd2);
        #1 reset = 1'b1;
        #1;
        chk("rs_we",    32'(if_g4.mem_we), 32'd0);
        chk("rs_cnt",   32'(if_g4.fifo_count), 32'd0);
        chk("rs_addr",  32'(if_g4.mem_addr), 32'd0);
        chk("rs_idle",  32'(if_g4.idle), 32'd1);
        chk("rs_ready", 32'(if_g4.ld_ready), 32'd0);
        drive4(1'b0, '0, 8'h00, 1'b0, '0, 8'h00, 1'b0);
        step();
        #2 reset = 1'b0;
        #1 chk("rs_rel_ready", 32'(if_g4.ld_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("rs_quiet%0d", i), 32'(if_g4.mem_we), 32'd0);
        end
        drive4(1'b1, 15'h0070, 8'hE7, 1'b0, '0, 8'h00, 1'b0);
        step(); exp4("rs_new1", 1'b0, '0, 8'h00, 3'd1);
        drive4(1'b0, '0, 8'h00, 1'b0, '0, 8'h00, 1'b0);
        step(); exp4("rs_new2", 1'b1, 15'h0070, 8'hE7, 3'd0);

        // ---------------- WRITE_GAP=0: 4 queued, consecutive drain ----------------
        for (int i = 0; i < 4; i++) begin
            if_g0.ld_valid  = 1'b1;
            if_g0.ld_addr   = AW'(16'h0080 + i);
            if_g0.ld_data   = 8'(8'hF0 + i);
            if_g0.core_wr   = (i > 0);
            if_g0.core_addr = 15'h1234;
            if_g0.core_data = 8'h55;
            step();
            chk($sformatf("g0_fill%0d_cnt", i), 32'(if_g0.fifo_count), 32'(i + 1));
            chk($sformatf("g0_fill%0d_we", i), 32'(if_g0.mem_we), 32'(i > 0));
        end
        if_g0.ld_valid = 1'b0;
        if_g0.core_wr  = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("g0_drain%0d_we", j),   32'(if_g0.mem_we), 32'd1);
            chk($sformatf("g0_drain%0d_addr", j), 32'(if_g0.mem_addr), 32'(16'h0080 + j));
            chk($sformatf("g0_drain%0d_data", j), 32'(if_g0.mem_data), 32'(8'hF0 + j));
            chk($sformatf("g0_drain%0d_cnt", j),  32'(if_g0.fifo_count), 32'(3 - j));
        end
        step();
        chk("g0_end_we",   32'(if_g0.mem_we), 32'd0);
        chk("g0_end_idle", 32'(if_g0.idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_loader_write_arbiter
